shift_left_pipe: RTL and testbench

- Two-stage pipelined lane shifter that moves a 50-bit word left, toward higher bits, by 0..4 lanes of 5 bits.
- Each vacated low lane is filled with a 5-bit fill value.
- It is the left-direction counterpart of the combinational right lane shifter on the same datapath, and uses the same lane packing.
- It adds valid/ready flow control, an illegal-shift flag and a saturating error counter.

---
 rtl/shift_left_pipe_if.sv | 63 ++++++
 rtl/shift_left_pipe.sv | 180 ++++++++++++++++++
 tb/tb_shift_left_pipe.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_left_pipe_if.sv
// shift_left_pipe_if: valid/ready streaming bus of the left lane shifter.
// The input side carries the word, shift amount and fill lane. The output
// side carries the shifted word, its illegal-shift flag and the error count.
// The rotate input exists only when SHIFT_LEFT_ROTATE_EN is defined.
interface shift_left_pipe_if #(
   parameter int LANE_W  = 5,
   parameter int LANES   = 10,
   parameter int SHIFT_W = 3,
   parameter int CNT_W   = 8
);

   // Input side
   logic                    in_valid;
   logic                    in_ready;
   logic [LANE_W*LANES-1:0] in;
   logic [SHIFT_W-1:0]      shift;
   logic [LANE_W-1:0]       fill;
`ifdef SHIFT_LEFT_ROTATE_EN
   logic                    rotate;
`endif

   // Output side
   logic                    out_valid;
   logic                    out_ready;
   logic [LANE_W*LANES-1:0] out;
   logic                    out_err;
   logic [CNT_W-1:0]        err_cnt;

   // Shifter view
   modport slave (
`ifdef SHIFT_LEFT_ROTATE_EN
      input  rotate,
`endif
      input  in_valid,
      input  in,
      input  shift,
      input  fill,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out,
      output out_err,
      output err_cnt
   );

   // Producer/consumer view
   modport master (
`ifdef SHIFT_LEFT_ROTATE_EN
      output rotate,
`endif
      output in_valid,
      output in,
      output shift,
      output fill,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out,
      input  out_err,
      input  err_cnt
   );

endinterface

// File: rtl/shift_left_pipe.sv
// shift_left_pipe: two-stage pipelined left lane shifter.
// A word of LANES lanes of LANE_W bits moves toward higher lanes by 0..MAX_SHIFT
// lanes. Vacated low lanes take the fill lane. Shift amounts above MAX_SHIFT
// produce an all-fill word flagged with out_err. err_cnt counts delivered
// illegal words and saturates.
// Stage 1 applies shift bits 0 and 1 (weights 1 and 2 lanes). Stage 2 applies
// shift bit 2 (weight 4 lanes) and the illegal override.
// Optional feature macro: SHIFT_LEFT_ROTATE_EN adds a rotate input. With it,
// vacated lanes of a legal shift take the lanes shifted out at the top
// (a lane rotation) instead of fill. Rotations by 1, 2 and 4 lanes compose
// exactly like the fill shifts do.
module shift_left_pipe #(
   parameter int LANE_W    = 5,
   parameter int LANES     = 10,
   parameter int SHIFT_W   = 3,
   parameter int MAX_SHIFT = 4,
   parameter int CNT_W     = 8
) (
   input logic              clk,
   input logic              rst_n,
   shift_left_pipe_if.slave bus
);

   localparam int DATA_W = LANE_W * LANES;

   typedef logic [DATA_W-1:0] word_t;
   typedef logic [LANE_W-1:0] lane_t;

   localparam logic [CNT_W-1:0]   CNT_MAX     = '1;
   localparam logic [SHIFT_W-1:0] SHIFT_LIMIT = SHIFT_W'(MAX_SHIFT);

   // Moves word up by a constant n lanes. Vacated lanes take fill_val, or the
   // top n lanes of the word when rot is set.
   function automatic word_t lane_shl(input word_t word, input int n,
                                      input lane_t fill_val, input logic rot);
      word_t res;
      res = '0;
      for (int i = 0; i < LANES; i++) begin
         if (i >= n) begin
            res[i*LANE_W +: LANE_W] = word[(i-n)*LANE_W +: LANE_W];
         end else if (rot) begin
            res[i*LANE_W +: LANE_W] = word[(LANES-n+i)*LANE_W +: LANE_W];
         end else begin
            res[i*LANE_W +: LANE_W] = fill_val;
         end
      end
      return res;
   endfunction

   // ------------------------------------------------------------------
   // Pipeline state
   // ------------------------------------------------------------------
   logic              s1_valid;
   word_t             s1_word;
   logic              s1_illegal;
   lane_t             s1_fill;
   logic              s1_hi;       // shift bit 2, applied in stage 2
   logic              s1_rot;

   logic              s2_valid;
   word_t             s2_word;
   logic              s2_err;

   logic [CNT_W-1:0]  err_cnt_q;

   // ------------------------------------------------------------------
   // Flow control
   // ------------------------------------------------------------------
   logic  s2_load;
   logic  s1_load;
   logic  in_fire;
   logic  out_fire;
   logic  in_rot;

   assign s2_load  = !s2_valid || bus.out_ready;
   assign s1_load  = !s1_valid || s2_load;
   assign in_fire  = bus.in_valid && bus.in_ready;
   assign out_fire = s2_valid && bus.out_ready;

   // Depends only on pipeline state and out_ready, never on in_valid.
   assign bus.in_ready = !s1_valid || !s2_valid || bus.out_ready;

`ifdef SHIFT_LEFT_ROTATE_EN
   assign in_rot = bus.rotate;
`else
   assign in_rot = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Stage 1: shift by shift[0]*1 + shift[1]*2 lanes
   // ------------------------------------------------------------------
   word_t s1_next;
   logic  illegal_next;

   assign illegal_next = (bus.shift > SHIFT_LIMIT);

   // Partial shift of the incoming word by the two low shift bits.
   always_comb begin
      // NOTE: every always_comb output gets a default first; a path that
      // leaves it unassigned would infer a latch.
      s1_next = bus.in;
      if (bus.shift[0]) begin
         s1_next = lane_shl(s1_next, 1, bus.fill, in_rot);
      end
      if (bus.shift[1]) begin
         s1_next = lane_shl(s1_next, 2, bus.fill, in_rot);
      end
   end

   // Stage 1 register: accepts a word whenever it is empty or stage 2 moves.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples its inputs from before the edge.
         s1_valid   <= 1'b0;
         // NOTE: the data registers are plain flops, not a memory, so they
         // are reset along with the valid bits at no real cost.
         s1_word    <= '0;
         s1_illegal <= 1'b0;
         s1_fill    <= '0;
         s1_hi      <= 1'b0;
         s1_rot     <= 1'b0;
      end else if (s1_load) begin
         s1_valid <= bus.in_valid;
         if (in_fire) begin
            s1_word    <= s1_next;
            s1_illegal <= illegal_next;
            s1_fill    <= bus.fill;
            s1_hi      <= bus.shift[2];
            s1_rot     <= in_rot;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: shift by shift[2]*4 lanes, or all-fill for an illegal shift
   // ------------------------------------------------------------------
   word_t s2_next;

   // Final shift step and illegal override of the stage-1 word.
   always_comb begin
      s2_next = s1_word;
      if (s1_hi) begin
         s2_next = lane_shl(s1_word, 4, s1_fill, s1_rot);
      end
      if (s1_illegal) begin
         s2_next = {LANES{s1_fill}};
      end
   end

   // Stage 2 register: holds its word while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_word  <= '0;
         s2_err   <= 1'b0;
      end else if (s2_load) begin
         s2_valid <= s1_valid;
         s2_err   <= s1_valid && s1_illegal;
         if (s1_valid) begin
            s2_word <= s2_next;
         end
      end
   end

   // Saturating count of illegal words handed to the consumer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_q <= '0;
      end else if (out_fire && s2_err && (err_cnt_q != CNT_MAX)) begin
         err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
   end

   assign bus.out_valid = s2_valid;
   assign bus.out       = s2_word;
   assign bus.out_err   = s2_err;
   assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_shift_left_pipe.sv
// tb_shift_left_pipe: scoreboard bench for shift_left_pipe.
// Expected words come from a lane-by-lane model of the full shift amount,
// pushed when an input transfer happens and popped on each output transfer.
module tb_shift_left_pipe;

   localparam int LANE_W    = 5;
   localparam int LANES     = 10;
   localparam int DATA_W    = LANE_W * LANES;
   localparam int SHIFT_W   = 3;
   localparam int MAX_SHIFT = 4;
   localparam int CNT_W     = 8;

   typedef struct {
      logic [DATA_W-1:0]  data;
      logic [SHIFT_W-1:0] shift;
      logic [LANE_W-1:0]  fill;
      logic               rot;
   } item_t;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              err;
      int                acc_cycle;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_cnt = 0;

   item_t stim_q[$];
   exp_t  sb[$];

   always #5 clk = ~clk;

   shift_left_pipe_if #(.LANE_W(LANE_W), .LANES(LANES), .SHIFT_W(SHIFT_W), .CNT_W(CNT_W)) bus ();

   shift_left_pipe #(
      .LANE_W(LANE_W), .LANES(LANES), .SHIFT_W(SHIFT_W),
      .MAX_SHIFT(MAX_SHIFT), .CNT_W(CNT_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Word whose lane k holds k+1.
   function automatic logic [DATA_W-1:0] seq_word();
      logic [DATA_W-1:0] w;
      w = '0;
      for (int k = 0; k < LANES; k++) w[k*LANE_W +: LANE_W] = LANE_W'(k + 1);
      return w;
   endfunction

   function automatic logic [DATA_W-1:0] rand_word();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return r[DATA_W-1:0];
   endfunction

   function automatic item_t mk(input logic [DATA_W-1:0] d, input int s,
                                input logic [LANE_W-1:0] f, input logic r);
      item_t it;
      it.data  = d;
      it.shift = SHIFT_W'(s);
      it.fill  = f;
      it.rot   = r;
      return it;
   endfunction

   // Reference: lane i of the result for the whole shift amount at once.
   function automatic exp_t model(input item_t it, input int cyc);
      exp_t e;
      int   s;
      logic rot;
      s   = int'(it.shift);
      rot = 1'b0;
`ifdef SHIFT_LEFT_ROTATE_EN
      rot = it.rot;
`endif
      e.err       = (s > MAX_SHIFT);
      e.acc_cycle = cyc;
      e.data      = '0;
      for (int i = 0; i < LANES; i++) begin
         if (e.err)        e.data[i*LANE_W +: LANE_W] = it.fill;
         else if (i >= s)  e.data[i*LANE_W +: LANE_W] = it.data[(i-s)*LANE_W +: LANE_W];
         else if (rot)     e.data[i*LANE_W +: LANE_W] = it.data[(LANES-s+i)*LANE_W +: LANE_W];
         else              e.data[i*LANE_W +: LANE_W] = it.fill;
      end
      return e;
   endfunction

   task automatic drive_item(input item_t it);
      bus.in_valid = 1'b1;
      bus.in       = it.data;
      bus.shift    = it.shift;
      bus.fill     = it.fill;
`ifdef SHIFT_LEFT_ROTATE_EN
      bus.rotate   = it.rot;
`endif
   endtask

   task automatic idle_inputs();
      bus.in_valid  = 1'b0;
      bus.in        = '0;
      bus.shift     = '0;
      bus.fill      = '0;
      bus.out_ready = 1'b0;
`ifdef SHIFT_LEFT_ROTATE_EN
      bus.rotate    = 1'b0;
`endif
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      exp_cnt = 0;
      sb.delete();
   endtask

   // Streams stim_q through the DUT. out_ready is low during cycles
   // stall_lo..stall_hi (counted from the first driven cycle). Checks data,
   // err flag, order, in_ready, stall stability and optionally latency.
   task automatic run_stream(input int stall_lo, input int stall_hi, input bit chk_lat);
      int n, idx, got, cyc, occ, budget;
      bit in_fire, out_fire, prev_stall, exp_rdy;
      logic [DATA_W-1:0] prev_out;
      logic prev_err;
      exp_t e;
      n = stim_q.size();
      idx = 0; got = 0; cyc = 0; occ = 0;
      budget = n * 4 + 40;
      prev_stall = 1'b0; prev_out = '0; prev_err = 1'b0;
      while ((got < n) && (cyc < budget)) begin
         bus.out_ready = !((cyc >= stall_lo) && (cyc <= stall_hi));
         if (idx < n) drive_item(stim_q[idx]);
         else bus.in_valid = 1'b0;
         @(negedge clk);
         exp_rdy = (occ < 2) || bus.out_ready;
         n_cmp++;
         if (bus.in_ready !== exp_rdy) begin
            n_bad++;
            $display("FAIL in_ready cyc %0d: got %b expected %b", cyc, bus.in_ready, exp_rdy);
         end
         if (prev_stall) begin
            n_cmp++;
            if ((bus.out_valid !== 1'b1) || (bus.out !== prev_out) || (bus.out_err !== prev_err)) begin
               n_bad++;
               $display("FAIL stall_hold cyc %0d: got v=%b %h e=%b expected v=1 %h e=%b",
                        cyc, bus.out_valid, bus.out, bus.out_err, prev_out, prev_err);
            end
         end
         out_fire = (bus.out_valid === 1'b1) && bus.out_ready;
         in_fire  = (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1);
         if (out_fire) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_bad++;
               $display("FAIL extra_word cyc %0d: got %h expected no word", cyc, bus.out);
            end else begin
               e = sb.pop_front();
               if ((bus.out !== e.data) || (bus.out_err !== e.err)) begin
                  n_bad++;
                  $display("FAIL out_word cyc %0d: got %h err=%b expected %h err=%b",
                           cyc, bus.out, bus.out_err, e.data, e.err);
               end
               if (chk_lat) begin
                  n_cmp++;
                  if (cyc - e.acc_cycle != 2) begin
                     n_bad++;
                     $display("FAIL latency: got %0d expected 2", cyc - e.acc_cycle);
                  end
               end
               if (e.err && exp_cnt < 255) exp_cnt++;
            end
            got++;
         end
         if (in_fire) begin
            sb.push_back(model(stim_q[idx], cyc));
            idx++;
         end
         occ = occ + int'(in_fire) - int'(out_fire);
         prev_stall = (bus.out_valid === 1'b1) && !bus.out_ready;
         prev_out   = bus.out;
         prev_err   = bus.out_err;
         @(posedge clk);
         #1;
         cyc++;
      end
      n_cmp++;
      if (got != n) begin
         n_bad++;
         $display("FAIL stream_timeout: got %0d words expected %0d", got, n);
      end
      bus.in_valid = 1'b0;
      stim_q.delete();
      n_cmp++;
      if (bus.err_cnt !== CNT_W'(exp_cnt)) begin
         n_bad++;
         $display("FAIL err_cnt: got %0d expected %0d", bus.err_cnt, exp_cnt);
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if ((bus.out_valid !== 1'b0) || (bus.out_err !== 1'b0) || (bus.out !== '0) ||
          (bus.err_cnt !== '0) || (bus.in_ready !== 1'b1)) begin
         n_bad++;
         $display("FAIL reset_state: got v=%b e=%b out=%h cnt=%0d rdy=%b expected 0 0 0 0 1",
                  bus.out_valid, bus.out_err, bus.out, bus.err_cnt, bus.in_ready);
      end
   endtask

   task automatic test_basic();
      do_reset();
      stim_q.push_back(mk(seq_word(), 2, 5'h1F, 1'b0));
      run_stream(-1, -1, 1'b1);
   endtask

   task automatic test_back_to_back();
      do_reset();
      stim_q.push_back(mk(seq_word(), 0, 5'h1F, 1'b0));
      stim_q.push_back(mk(seq_word(), 4, 5'h1F, 1'b0));
      for (int k = 0; k < 10; k++)
         stim_q.push_back(mk(rand_word(), $urandom_range(0, 7), LANE_W'($urandom), 1'b0));
      run_stream(-1, -1, 1'b1);
   endtask

   task automatic test_illegal();
      do_reset();
      for (int s = 5; s <= 7; s++) stim_q.push_back(mk(rand_word(), s, 5'h0A, 1'b0));
      run_stream(-1, -1, 1'b1);
      n_cmp++;
      if (bus.err_cnt !== 8'd3) begin
         n_bad++;
         $display("FAIL illegal_count: got %0d expected 3", bus.err_cnt);
      end
   endtask

   task automatic test_stall();
      do_reset();
      for (int k = 0; k < 6; k++)
         stim_q.push_back(mk(rand_word(), $urandom_range(0, 5), LANE_W'($urandom), 1'b0));
      run_stream(3, 7, 1'b0);
   endtask

   task automatic test_saturate();
      do_reset();
      for (int k = 0; k < 254; k++)
         stim_q.push_back(mk(rand_word(), $urandom_range(5, 7), LANE_W'($urandom), 1'b0));
      run_stream(-1, -1, 1'b0);
      for (int k = 0; k < 3; k++)
         stim_q.push_back(mk(rand_word(), 7, 5'h03, 1'b0));
      run_stream(-1, -1, 1'b0);
      n_cmp++;
      if (bus.err_cnt !== 8'd255) begin
         n_bad++;
         $display("FAIL saturate: got %0d expected 255", bus.err_cnt);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      stim_q.push_back(mk(seq_word(), 6, 5'h11, 1'b0));
      run_stream(-1, -1, 1'b1);
      bus.out_ready = 1'b0;
      drive_item(mk(seq_word(), 1, 5'h02, 1'b0));
      @(posedge clk); #1;
      drive_item(mk(seq_word(), 3, 5'h04, 1'b0));
      @(posedge clk); #1;
      drive_item(mk(seq_word(), 5, 5'h06, 1'b0));
      n_cmp++;
      if ((bus.out_valid !== 1'b1) || (bus.in_ready !== 1'b0)) begin
         n_bad++;
         $display("FAIL full_before_reset: got v=%b rdy=%b expected v=1 rdy=0",
                  bus.out_valid, bus.in_ready);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ((bus.out_valid !== 1'b0) || (bus.err_cnt !== '0) || (bus.out !== '0) ||
          (bus.out_err !== 1'b0) || (bus.in_ready !== 1'b1)) begin
         n_bad++;
         $display("FAIL mid_reset: got v=%b cnt=%0d out=%h e=%b rdy=%b expected 0 0 0 0 1",
                  bus.out_valid, bus.err_cnt, bus.out, bus.out_err, bus.in_ready);
      end
      bus.in_valid = 1'b0;
      exp_cnt = 0;
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_cmp++;
         if (bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL stale_word cyc %0d: got out_valid=%b expected 0", k, bus.out_valid);
         end
      end
      @(posedge clk); #1;
      stim_q.push_back(mk(seq_word(), 4, 5'h15, 1'b0));
      run_stream(-1, -1, 1'b1);
   endtask

`ifdef SHIFT_LEFT_ROTATE_EN
   task automatic test_rotate();
      do_reset();
      stim_q.push_back(mk(seq_word(), 2, 5'h1F, 1'b1));
      stim_q.push_back(mk(seq_word(), 4, 5'h1F, 1'b1));
      stim_q.push_back(mk(seq_word(), 3, 5'h1F, 1'b0));
      stim_q.push_back(mk(seq_word(), 6, 5'h0A, 1'b1));
      for (int k = 0; k < 6; k++)
         stim_q.push_back(mk(rand_word(), $urandom_range(0, 7), LANE_W'($urandom), 1'($urandom)));
      run_stream(-1, -1, 1'b1);
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_illegal();
      test_stall();
      test_saturate();
      test_reset_mid();
`ifdef SHIFT_LEFT_ROTATE_EN
      test_rotate();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
